stream_rr_arbiter: RTL and testbench
====================================

# stream_rr_arbiter

Round-robin arbiter that shares one 8-bit ready/valid stream channel, the `stream_in_*` input of the sample datapath, between `NUM_REQ` upstream requesters. Grants are packet-locked: a requester holds the channel from its grant until its `last` beat is accepted. The block sits directly in front of the datapath's stream input. It also exposes the current grant, a busy flag and a completed-packet counter for debug and test.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `DATA_W`, default 8: beat width; matches `stream_in_data`.
- `CNT_W`, default 16: width of the completed-packet counter.
- `ID_W`, localparam `$clog2(NUM_REQ)`: grant index width.

- `clk`  in  1  sole clock; all logic on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  NUM_REQ  per-requester valid.
- `req_data`  in  NUM_REQ*DATA_W  flattened data; requester k occupies bits [k*DATA_W +: DATA_W].
- `req_last`  in  NUM_REQ  per-requester end-of-packet flag.
- `req_ready`  out  NUM_REQ  per-requester ready; at most one bit high at any time.
- `out_valid`  out  1  valid to the datapath (drives `stream_in_valid`).
- `out_data`  out  DATA_W  data to the datapath.
- `out_last`  out  1  end-of-packet flag to the datapath.
- `out_ready`  in  1  ready from the datapath (`stream_in_ready`).
- `grant_id`  out  ID_W  currently or most recently granted requester.
- `busy`  out  1  high while in LOCKED.
- `pkt_count`  out  CNT_W  number of completed packets; wraps modulo 2^CNT_W.

## Operation
- The FSM has two states, IDLE and LOCKED; the state type lives in the package.
- IDLE behaviour:
  - `out_valid` = 0 and `req_ready` = 0.
  - If any `req_valid` is high, `rr_pick` selects the first valid requester strictly after `last_grant`, scanning upward with wrap-around.
  - On the next edge, register it into `grant_id` and enter LOCKED.
  - If no `req_valid` is high, stay in IDLE.
- LOCKED behaviour, with g = `grant_id`:
  - The mux is combinational: `out_valid` = `req_valid[g]`, `out_data` = `req_data[g]`, `out_last` = `req_last[g]`, and `req_ready[g]` = `out_ready`.
  - All other `req_ready` bits are 0.
  - A beat transfers when `req_valid[g]` and `out_ready` are both high.
- Packet end: a transfer with `req_last[g]` = 1 causes, on that edge, `last_grant` <= g, `pkt_count` += 1 and a return to IDLE.
- Valid dropping mid-packet: if `req_valid[g]` falls mid-packet, the block stays LOCKED. There is no timeout and no re-arbitration until `last` is accepted.
- Other requesters' `req_valid` in LOCKED are ignored; they are considered at the next IDLE.
- Requesters must hold their data stable while valid and not ready. The arbiter adds no storage.
- Arithmetic: `pkt_count` wraps from 2^CNT_W−1 to 0. The `rr_pick` scan is modulo NUM_REQ.

## Timing
- Reset values (registered on the first `rst` edge):
  - state = IDLE, `grant_id` = 0, `last_grant` = NUM_REQ−1 (so the first grant goes to requester 0), `pkt_count` = 0, `busy` = 0.
  - `out_valid`, `out_last` and `req_ready` are therefore 0; `out_data` is don't-care.
- Arbitration latency: 1 cycle from `req_valid` sampled in IDLE to first possible transfer.
- Packet spacing: exactly one idle bubble cycle between back-to-back packets.
- A single-beat packet occupies 2 cycles.
- Throughput within a packet is 1 beat/cycle. The datapath-side ready-to-requester-side ready path is zero latency (combinational).
- Simultaneous events: `last` accepted and new requests present in the same cycle → IDLE next cycle, then grant to the successor of g.
- Reset mid-packet: abort immediately. Cycle after `rst` shows reset values; the partial packet is not counted.
- `rst` has priority over every other transition.

## Structure
- Package `stream_arb_pkg` holds:
  - the `arb_state_t` enum {IDLE, LOCKED};
  - the shared `test_struct_packed` typedef, moved here from the compilation-unit scope so both blocks import it.
- Sub-module `rr_pick`, purely combinational:
  - inputs `req` [NUM_REQ] and `last` [ID_W];
  - outputs `any` and `sel` [ID_W].
- `stream_rr_arbiter` holds the FSM, the grant and count registers, and the output mux.

## Test plan
- **Single packet:** requester 2 sends 3 beats 0x11, 0x22, 0x33 (`last` on 0x33) with `out_ready` = 1.
  - `grant_id` = 2 and `busy` = 1 one cycle after valid.
  - `out_data` is 0x11, 0x22, 0x33 on consecutive cycles.
  - `req_ready` = 4'b0100 for those 3 cycles.
  - `pkt_count` = 1 and `busy` = 0 afterwards.
- **Fairness:** all 4 requesters continuously offer single-beat packets (data = 0xA0+k).
  - Grant order is 0, 1, 2, 3, 0, 1.
  - Each packet takes 2 cycles.
  - `pkt_count` = 6 after 12 cycles.
- **Backpressure:** `out_ready` = 0 for 4 cycles during beat 2 of a 3-beat packet.
  - `out_data` is held at beat-2 data and `req_ready` = 0 during the stall.
  - No beat is lost or duplicated; total transfers = 3.
- **Valid gap:** granted requester 1 drops `req_valid` for 3 cycles mid-packet while requester 3 is valid.
  - `out_valid` = 0 for 3 cycles and `grant_id` stays 1.
  - Requester 3 is granted only after 1's `last` is accepted.
- **Reset mid-packet:** assert `rst` during beat 2 of requester 3's packet.
  - Next cycle: `out_valid` = 0, `req_ready` = 0, `busy` = 0, `pkt_count` = 0.
  - With all requesters valid after release, the first grant is requester 0.
- **Counter wrap:** with `CNT_W` = 4, complete 17 single-beat packets; `pkt_count` reads 15, 0, 1 after packets 15, 16 and 17.

Source files
------------

// File: rtl/stream_rr_arbiter_pkg.sv
// stream_arb_pkg: types shared by the round-robin stream arbiter and its
// round-robin picker.
//   arb_state_t        : arbiter FSM state (IDLE, LOCKED)
//   test_struct_packed : one stream beat (data + end-of-packet flag)
package stream_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } test_struct_packed;

endpackage

// File: rtl/stream_rr_arbiter_rr_pick.sv
// rr_pick: purely combinational round-robin selector.
// Ports:
//   req  [NUM_REQ] : request vector
//   last [ID_W]    : most recently granted index
//   any            : at least one request is high
//   sel  [ID_W]    : first requester strictly after 'last', scanning upward
//                    with wrap-around; equals 'last' when 'any' is low
module rr_pick
  import stream_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic               any,
  output logic [ID_W-1:0]    sel
);

  int             idx;
  logic [ID_W-1:0] cand;

  // Offsets 1..NUM_REQ visit every index once, ending on 'last' itself, so
  // a lone requester that was just served still wins.
  always_comb begin
    any  = 1'b0;
    sel  = last;
    idx  = 0;
    cand = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx  = (int'(last) + i) % NUM_REQ;
      cand = ID_W'(idx);
      if (!any && req[cand]) begin
        any = 1'b1;
        sel = cand;
      end
    end
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: packet-locked round-robin arbiter sharing one
// ready/valid stream channel between NUM_REQ requesters.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/data/last : per-requester stream inputs (data flattened,
//                         requester k at [k*DATA_W +: DATA_W])
//   req_ready           : per-requester ready, one-hot or zero
//   out_valid/data/last : muxed stream to the datapath
//   out_ready           : datapath ready
//   grant_id            : current / most recent grant
//   busy                : high while LOCKED (FSM state visibility)
//   pkt_count           : completed packets, wraps modulo 2^CNT_W
//
// Handshake: a beat moves on a rising edge where valid and ready are both
// high; a source holds data/last stable while valid is high and ready low;
// ready may depend combinationally on the downstream ready.
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 16,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy,
  output logic [CNT_W-1:0]          pkt_count
);

  arb_state_t      state, next_state;
  logic [ID_W-1:0] last_grant;
  logic            pick_any;
  logic [ID_W-1:0] pick_sel;
  logic            pkt_done;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req  (req_valid),
    .last (last_grant),
    .any  (pick_any),
    .sel  (pick_sel)
  );

  // Output mux and next state. out_data follows grant_id even in IDLE; it
  // is only meaningful while out_valid is high.
  always_comb begin
    next_state = state;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    out_data   = req_data[int'(grant_id)*DATA_W +: DATA_W];
    req_ready  = '0;
    pkt_done   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) next_state = LOCKED;
      end
      LOCKED: begin
        out_valid           = req_valid[grant_id];
        out_last            = req_last[grant_id];
        req_ready[grant_id] = out_ready;
        // The grant is held through valid gaps; only an accepted last
        // beat releases the channel.
        pkt_done = req_valid[grant_id] && out_ready && req_last[grant_id];
        if (pkt_done) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      pkt_count  <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && pick_any) grant_id <= pick_sel;
      if (pkt_done) begin
        last_grant <= grant_id;
        pkt_count  <= pkt_count + CNT_W'(1);
      end
    end
  end

  assign busy = (state == LOCKED);

endmodule

// File: tb/tb_stream_rr_arbiter.sv
module tb_stream_rr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int CNT_W   = 4;
  localparam int ID_W    = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ*DATA_W-1:0] req_data  = '0;
  logic [NUM_REQ-1:0]        req_last  = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic                      out_last;
  logic                      out_ready = 1'b0;
  logic [ID_W-1:0]           grant_id;
  logic                      busy;
  logic [CNT_W-1:0]          pkt_count;

  stream_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .grant_id  (grant_id),
    .busy      (busy),
    .pkt_count (pkt_count)
  );

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  int exp_cnt = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] got_q[$];
  logic mon_en = 1'b0;

  always @(posedge clk)
    if (mon_en && out_valid && out_ready) got_q.push_back(out_data);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beats(input string tag);
    chk({tag, "_nbeats"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({tag, "_beat"}, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock; inputs are driven 1 time unit after the edge and
  // outputs checked after another unit of settling.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_data(input int k, input logic [DATA_W-1:0] v);
    req_data[k*DATA_W +: DATA_W] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic chk_cnt(input string tag);
    chk(tag, 32'(pkt_count), 32'(exp_cnt % 16));
  endtask

  // ---------------- directed steps ----------------
  initial begin
    do_reset();
    settle();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_last",  32'(out_last), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_busy",      32'(busy), 0);
    chk("rst_grant",     32'(grant_id), 0);
    chk_cnt("rst_count");

    // ---- single packet from requester 2 ----
    mon_en = 1'b1;
    out_ready = 1'b1;
    req_valid = 4'b0100;
    set_data(2, 8'h11);
    req_last  = 4'b0000;
    settle();
    chk("sp_idle_valid", 32'(out_valid), 0);
    chk("sp_idle_ready", 32'(req_ready), 0);
    cyc();
    settle();
    chk("sp_grant", 32'(grant_id), 2);
    chk("sp_busy",  32'(busy), 1);
    chk("sp_d0",    32'(out_data), 32'h11);
    chk("sp_rdy0",  32'(req_ready), 32'b0100);
    cyc();
    set_data(2, 8'h22);
    settle();
    chk("sp_d1",   32'(out_data), 32'h22);
    chk("sp_rdy1", 32'(req_ready), 32'b0100);
    cyc();
    set_data(2, 8'h33);
    req_last = 4'b0100;
    settle();
    chk("sp_d2",   32'(out_data), 32'h33);
    chk("sp_last", 32'(out_last), 1);
    chk("sp_rdy2", 32'(req_ready), 32'b0100);
    cyc();
    req_valid = '0;
    req_last  = '0;
    exp_cnt++;
    settle();
    chk("sp_done_busy", 32'(busy), 0);
    chk_cnt("sp_done_count");
    exp_q = '{8'h11, 8'h22, 8'h33};
    chk_beats("sp");

    // ---- fairness: all four offer single-beat packets ----
    do_reset();
    for (int k = 0; k < NUM_REQ; k++) set_data(k, 8'hA0 + 8'(k));
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    for (int p = 0; p < 6; p++) begin
      cyc();
      settle();
      chk("fair_grant", 32'(grant_id), 32'(p % 4));
      chk("fair_data",  32'(out_data), 32'h A0 + 32'(p % 4));
      chk("fair_ready", 32'(req_ready), 32'(1 << (p % 4)));
      exp_q.push_back(8'hA0 + 8'(p % 4));
      cyc();
      exp_cnt++;
      if (p == 5) req_valid = '0;
      settle();
      chk("fair_bubble", 32'(busy), 0);
      chk_cnt("fair_count");
    end
    chk_beats("fair");

    // ---- backpressure during beat 2 of a 3-beat packet (requester 0) ----
    req_valid = 4'b0001;
    req_last  = 4'b0000;
    set_data(0, 8'hB1);
    cyc();
    settle();
    chk("bp_grant", 32'(grant_id), 0);
    chk("bp_d0",    32'(out_data), 32'hB1);
    cyc();
    set_data(0, 8'hB2);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("bp_hold_data",  32'(out_data), 32'hB2);
      chk("bp_hold_ready", 32'(req_ready), 0);
      chk("bp_hold_valid", 32'(out_valid), 1);
      if (i < 3) cyc();
      else begin
        @(posedge clk);
        #1;
      end
    end
    out_ready = 1'b1;
    settle();
    chk("bp_resume_ready", 32'(req_ready), 32'b0001);
    cyc();
    set_data(0, 8'hB3);
    req_last = 4'b0001;
    cyc();
    req_valid = '0;
    req_last  = '0;
    exp_cnt++;
    settle();
    chk("bp_done_busy", 32'(busy), 0);
    chk_cnt("bp_count");
    exp_q = '{8'hB1, 8'hB2, 8'hB3};
    chk_beats("bp");

    // ---- valid gap on requester 1 while requester 3 waits ----
    req_valid = 4'b1010;
    req_last  = 4'b1000;
    set_data(1, 8'hC1);
    set_data(3, 8'hD1);
    cyc();
    settle();
    chk("vg_grant", 32'(grant_id), 1);
    chk("vg_d0",    32'(out_data), 32'hC1);
    cyc();
    req_valid = 4'b1000;
    set_data(1, 8'hC2);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("vg_gap_valid", 32'(out_valid), 0);
      chk("vg_gap_grant", 32'(grant_id), 1);
      chk("vg_gap_busy",  32'(busy), 1);
      cyc();
    end
    req_valid = 4'b1010;
    req_last  = 4'b1010;
    settle();
    chk("vg_d1",   32'(out_data), 32'hC2);
    chk("vg_last", 32'(out_last), 1);
    cyc();
    exp_cnt++;
    settle();
    chk("vg_bubble_busy",  32'(busy), 0);
    chk("vg_bubble_grant", 32'(grant_id), 1);
    cyc();
    settle();
    chk("vg_grant3", 32'(grant_id), 3);
    chk("vg_d3",     32'(out_data), 32'hD1);
    cyc();
    req_valid = '0;
    req_last  = '0;
    exp_cnt++;
    settle();
    chk_cnt("vg_count");
    exp_q = '{8'hC1, 8'hC2, 8'hD1};
    chk_beats("vg");
    mon_en = 1'b0;

    // ---- reset in the middle of requester 3's packet ----
    req_valid = 4'b1000;
    set_data(3, 8'hE1);
    cyc();
    settle();
    chk("rm_grant", 32'(grant_id), 3);
    cyc();
    set_data(3, 8'hE2);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    exp_cnt = 0;
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    for (int k = 0; k < NUM_REQ; k++) set_data(k, 8'hA0 + 8'(k));
    settle();
    chk("rm_out_valid", 32'(out_valid), 0);
    chk("rm_req_ready", 32'(req_ready), 0);
    chk("rm_busy",      32'(busy), 0);
    chk_cnt("rm_count");
    cyc();
    settle();
    chk("rm_first_grant", 32'(grant_id), 0);
    cyc();
    req_valid = '0;
    req_last  = '0;
    exp_cnt++;
    settle();
    chk_cnt("rm_after_count");

    // ---- counter wrap with a 4-bit counter ----
    do_reset();
    req_valid = 4'b0001;
    req_last  = 4'b0001;
    for (int n = 1; n <= 17; n++) begin
      cyc();
      cyc();
      exp_cnt++;
      settle();
      chk("wrap_count", 32'(pkt_count), 32'(n % 16));
    end
    req_valid = '0;
    req_last  = '0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
